pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/mc_tracker.sv | 84 ++++++++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Purpose : shared encodings for the pipeline hazard controller and its multi-cycle unit trackers.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

    // Per-unit multi-cycle execute FSM encoding.
    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    // Multi-cycle unit indices into the mc_* vectors.
    localparam int MC_DIV = 0;
    localparam int MC_MUL = 1;

    // Execute-stage operand source select.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/mc_tracker.sv
// Purpose : tracks one multi-cycle execute unit (IDLE/BUSY) with a hang timeout.
// Latency : stall is combinational from start/ready; busy/hang are registered (1 cycle).
// Backpressure: stall holds while the unit is occupied and has no result; a timeout releases it.
//
// Ports: clk, rst (sync, active-high); start/ready/exc from the pipeline;
//        busy = FSM in BUSY, hang = sticky timeout flag, stall = unit needs E frozen.
module mc_tracker
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ready,
    input  logic exc,
    output logic busy,
    output logic hang,
    output logic stall
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    mc_state_e     state;
    mc_state_e     state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_cnt_nxt;
    logic          hang_nxt;
    logic          stall_raw;
    logic          tmo_hit;

    // tmo_cnt holds the number of BUSY cycles already completed, so the
    // TIMEOUT-th BUSY cycle is the one that sees TIMEOUT-1.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        hang_nxt    = hang;
        stall_raw   = 1'b0;
        case (state)
            MC_IDLE: begin
                // A start that completes in the same cycle never occupies the unit.
                stall_raw = start & ~ready;
                if (start && !ready && !exc) begin
                    state_nxt   = MC_BUSY;
                    tmo_cnt_nxt = '0;
                end
            end
            MC_BUSY: begin
                stall_raw = ~ready;
                if (ready || exc) begin
                    state_nxt = MC_IDLE;
                end else if (tmo_hit) begin
                    // Give up on the unit: flag it and let the pipeline move.
                    state_nxt = MC_IDLE;
                    hang_nxt  = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TW'(1);
                end
            end
            default: begin
                state_nxt = MC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MC_IDLE;
            tmo_cnt <= '0;
            hang    <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            hang    <= hang_nxt;
        end
    end

    assign busy  = (state == MC_BUSY);
    // During reset the op is being aborted, so it must not hold the pipe.
    assign stall = stall_raw & ~rst;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : 5-stage pipeline hazard unit: bypass selects, load-use/branch/jr/multi-cycle stalls, flushes.
// Latency : forward/stall/flush outputs are combinational (0 cycles); mc_busy/mc_hang/stall_cnt registered.
// Backpressure: stallF/stallD freeze fetch/decode on any hazard; stallE freezes E only for multi-cycle ops.
//
// Ports: decode sources/control (rsD, rtD, branchD, jrD, jalrD, jumpD), execute state (rsE, rtE,
//        writeregE, regwriteE, memtoregE), multi-cycle start/ready, M/W writeback state, excM;
//        outputs forward selects, stalls, flushes, per-unit busy/hang and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int AW         = 5,
    parameter int NMC        = 2,
    parameter int MC_TIMEOUT = 64,
    parameter int CW         = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  rsD,
    input  logic [AW-1:0]  rtD,
    input  logic           branchD,
    input  logic           jrD,
    input  logic           jalrD,
    input  logic           jumpD,
    input  logic [AW-1:0]  rsE,
    input  logic [AW-1:0]  rtE,
    input  logic [AW-1:0]  writeregE,
    input  logic           regwriteE,
    input  logic           memtoregE,
    input  logic [NMC-1:0] mc_startE,
    input  logic [NMC-1:0] mc_readyE,
    input  logic [AW-1:0]  writeregM,
    input  logic [AW-1:0]  writeregW,
    input  logic           regwriteM,
    input  logic           memtoregM,
    input  logic           regwriteW,
    input  logic           excM,
    output logic           forwardaD,
    output logic           forwardbD,
    output logic [1:0]     forwardaE,
    output logic [1:0]     forwardbE,
    output logic           stallF,
    output logic           stallD,
    output logic           stallE,
    output logic           flushD,
    output logic           flushE,
    output logic           flushM,
    output logic [NMC-1:0] mc_busy,
    output logic [NMC-1:0] mc_hang,
    output logic [CW-1:0]  stall_cnt
);

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // The youngest producer (M) wins over W.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
        if (regwriteM && reg_hit(src, writeregM)) begin
            return FWD_M;
        end else if (regwriteW && reg_hit(src, writeregW)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    logic           lwstall;
    logic           brstall;
    logic           jrstall;
    logic           mcstall;
    logic           hz_stall;
    logic [NMC-1:0] mc_stall;

    // ---------------- multi-cycle unit trackers ----------------
    for (genvar i = 0; i < NMC; i++) begin : g_mc
        mc_tracker #(
            .TIMEOUT (MC_TIMEOUT)
        ) u_mc_tracker (
            .clk   (clk),
            .rst   (rst),
            .start (mc_startE[i]),
            .ready (mc_readyE[i]),
            .exc   (excM),
            .busy  (mc_busy[i]),
            .hang  (mc_hang[i]),
            .stall (mc_stall[i])
        );
    end

    assign mcstall = |mc_stall;

    // ---------------- forwarding ----------------
    assign forwardaD = regwriteM & reg_hit(rsD, writeregM);
    assign forwardbD = regwriteM & reg_hit(rtD, writeregM);
    assign forwardaE = fwd_sel(rsE);
    assign forwardbE = fwd_sel(rtE);

    // ---------------- hazard detection ----------------
    assign lwstall = memtoregE & (reg_hit(rtE, rsD) | reg_hit(rtE, rtD));

    // Branches resolve in D, so they wait on an ALU result still in E or a load still in M.
    assign brstall = branchD &
                     ((regwriteE & (reg_hit(writeregE, rsD) | reg_hit(writeregE, rtD))) |
                      (memtoregM & (reg_hit(writeregM, rsD) | reg_hit(writeregM, rtD))));

    assign jrstall = (jrD | jalrD) &
                     ((regwriteE & reg_hit(writeregE, rsD)) |
                      (memtoregM & reg_hit(writeregM, rsD)));

    assign hz_stall = lwstall | brstall | jrstall;

    // An exception in M flushes everything younger; a flush overrides every stall.
    assign stallF = (hz_stall | mcstall) & ~excM;
    assign stallD = (hz_stall | mcstall) & ~excM;
    assign stallE = mcstall & ~excM;

    // While E is frozen by a multi-cycle op, E still holds a live instruction,
    // so no bubble may be injected into it.
    assign flushE = ((hz_stall | jumpD) & ~mcstall) | excM;
    assign flushD = excM;
    assign flushM = excM;

    // ---------------- stall-cycle counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stallD && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int AW  = 5;
    localparam int NMC = 2;
    localparam int TMO = 8;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic           branchD, jrD, jalrD, jumpD;
    logic           regwriteE, memtoregE, regwriteM, memtoregM, regwriteW, excM;
    logic [NMC-1:0] mc_startE, mc_readyE;
    logic           forwardaD, forwardbD;
    logic [1:0]     forwardaE, forwardbE;
    logic           stallF, stallD, stallE, flushD, flushE, flushM;
    logic [NMC-1:0] mc_busy, mc_hang;
    logic [CW-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: per-unit occupancy, busy-cycle count, hang flag; stall counter.
    bit m_busy [NMC];
    int m_n    [NMC];
    bit m_hang [NMC];
    int m_scnt;

    pipe_hazard_ctrl #(.AW(AW), .NMC(NMC), .MC_TIMEOUT(TMO), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD), .jalrD(jalrD), .jumpD(jumpD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
        .mc_startE(mc_startE), .mc_readyE(mc_readyE),
        .writeregM(writeregM), .writeregW(writeregW), .regwriteM(regwriteM),
        .memtoregM(memtoregM), .regwriteW(regwriteW), .excM(excM),
        .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .mc_busy(mc_busy), .mc_hang(mc_hang), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] src);
        if (regwriteM && hit(src, writeregM)) return 2'b10;
        if (regwriteW && hit(src, writeregW)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeregE = 0; writeregM = 0; writeregW = 0;
        branchD = 0; jrD = 0; jalrD = 0; jumpD = 0;
        regwriteE = 0; memtoregE = 0; regwriteM = 0; memtoregM = 0; regwriteW = 0; excM = 0;
        mc_startE = 0; mc_readyE = 0; rst = 0;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NMC; i++) begin
            m_busy[i] = 0; m_n[i] = 0; m_hang[i] = 0;
        end
        m_scnt = 0;
    endfunction

    // Called just after a rising edge with this cycle's inputs already applied.
    task automatic do_cycle();
        bit lw, br, jr, mc, e_sd;
        logic [NMC-1:0] e_busy, e_hang;
        #1;
        for (int i = 0; i < NMC; i++) begin
            e_busy[i] = m_busy[i];
            e_hang[i] = m_hang[i];
        end
        chk("mc_busy", 32'(mc_busy), 32'(e_busy));
        chk("mc_hang", 32'(mc_hang), 32'(e_hang));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));

        lw = memtoregE && (hit(rtE, rsD) || hit(rtE, rtD));
        br = branchD && ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
                         (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));
        jr = (jrD || jalrD) && ((regwriteE && hit(writeregE, rsD)) ||
                                (memtoregM && hit(writeregM, rsD)));
        mc = 0;
        for (int i = 0; i < NMC; i++)
            if (!rst && (m_busy[i] || mc_startE[i]) && !mc_readyE[i]) mc = 1;
        e_sd = (lw || br || jr || mc) && !excM;

        chk("forwardaD", 32'(forwardaD), 32'(regwriteM && hit(rsD, writeregM)));
        chk("forwardbD", 32'(forwardbD), 32'(regwriteM && hit(rtD, writeregM)));
        chk("forwardaE", 32'(forwardaE), 32'(exp_fwd(rsE)));
        chk("forwardbE", 32'(forwardbE), 32'(exp_fwd(rtE)));
        chk("stallF", 32'(stallF), 32'(e_sd));
        chk("stallD", 32'(stallD), 32'(e_sd));
        chk("stallE", 32'(stallE), 32'(mc && !excM));
        chk("flushD", 32'(flushD), 32'(excM));
        chk("flushM", 32'(flushM), 32'(excM));
        chk("flushE", 32'(flushE), 32'(excM || ((lw || br || jr || jumpD) && !mc)));

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NMC; i++) begin
                if (!m_busy[i]) begin
                    if (mc_startE[i] && !mc_readyE[i] && !excM) begin
                        m_busy[i] = 1; m_n[i] = 0;
                    end
                end else if (mc_readyE[i] || excM) begin
                    m_busy[i] = 0;
                end else begin
                    m_n[i]++;
                    if (m_n[i] == TMO) begin
                        m_busy[i] = 0; m_hang[i] = 1;
                    end
                end
            end
            if (e_sd && m_scnt < (1 << CW) - 1) m_scnt++;
        end
        #1;
    endtask

    task automatic reset_cycle();
        clear_inputs(); rst = 1; do_cycle(); rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        do_cycle();
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        clear_inputs();

        // Load-use hazard, then register 0 never hazards.
        memtoregE = 1; rtE = 5; rsD = 5;
        #1;
        chk("lw_stallD", 32'(stallD), 32'd1);
        chk("lw_flushE", 32'(flushE), 32'd1);
        chk("lw_stallE", 32'(stallE), 32'd0);
        do_cycle();
        rtE = 0; rsD = 0;
        #1;
        chk("r0_stallD", 32'(stallD), 32'd0);
        do_cycle();
        clear_inputs();

        // Forward priority M over W.
        rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
        #1;
        chk("fwdE_M", 32'(forwardaE), 32'(FWD_M));
        do_cycle();
        regwriteM = 0;
        #1;
        chk("fwdE_W", 32'(forwardaE), 32'(FWD_W));
        do_cycle();
        clear_inputs();

        // Divider op completing after 6 busy cycles.
        reset_cycle();
        mc_startE[MC_DIV] = 1;
        do_cycle();
        mc_startE = 0;
        repeat (6) do_cycle();
        mc_readyE[MC_DIV] = 1;
        do_cycle();
        mc_readyE = 0;
        chk("div_cnt", 32'(stall_cnt), 32'd7);
        do_cycle();

        // Divider never answers: times out, hang sticks until reset.
        mc_startE[MC_DIV] = 1;
        do_cycle();
        mc_startE = 0;
        repeat (TMO + 3) do_cycle();
        chk("hang_set", 32'(mc_hang[MC_DIV]), 32'd1);
        chk("hang_nostall", 32'(stallE), 32'd0);
        reset_cycle();
        chk("hang_clr", 32'(mc_hang), 32'd0);

        // Multiplier busy plus load-use, then exception flushes.
        mc_startE[MC_MUL] = 1;
        do_cycle();
        mc_startE = 0; memtoregE = 1; rtE = 7; rsD = 7;
        #1;
        chk("mul_stallE", 32'(stallE), 32'd1);
        chk("mul_noflushE", 32'(flushE), 32'd0);
        do_cycle();
        excM = 1;
        #1;
        chk("exc_flushD", 32'(flushD), 32'd1);
        chk("exc_stallD", 32'(stallD), 32'd0);
        do_cycle();
        clear_inputs();
        chk("exc_busy", 32'(mc_busy), 32'd0);

        // Stall counter saturation.
        reset_cycle();
        memtoregE = 1; rtE = 9; rtD = 9;
        repeat (20) do_cycle();
        chk("sat_cnt", 32'(stall_cnt), 32'd15);
        reset_cycle();
        chk("sat_rst", 32'(stall_cnt), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            rsD = AW'($urandom_range(0, 3)); rtD = AW'($urandom_range(0, 3));
            rsE = AW'($urandom_range(0, 3)); rtE = AW'($urandom_range(0, 3));
            writeregE = AW'($urandom_range(0, 3));
            writeregM = AW'($urandom_range(0, 3));
            writeregW = AW'($urandom_range(0, 3));
            branchD = ($urandom % 4) == 0; jrD = ($urandom % 8) == 0;
            jalrD = ($urandom % 8) == 0; jumpD = ($urandom % 6) == 0;
            regwriteE = 1'($urandom); memtoregE = ($urandom % 3) == 0;
            regwriteM = 1'($urandom); memtoregM = ($urandom % 3) == 0;
            regwriteW = 1'($urandom);
            r = $urandom % 8;
            mc_startE = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b00;
            mc_readyE[0] = ($urandom % 6) == 0;
            mc_readyE[1] = ($urandom % 6) == 0;
            excM = ($urandom % 25) == 0;
            rst = ($urandom % 80) == 0;
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
